// File: rtl/spi_slave_move_rx.sv
// SPI mode-0 slave that receives opponent moves (8-bit, MSB first) and
// returns a status byte on miso for every byte of the frame.
//
// Ports:
//   clk, rst_n          system clock (>= 8x sclk), async active-low reset
//   sclk, ss, mosi      SPI inputs from the external master (asynchronous)
//   miso, miso_oe       serial status out and its pad enable (ss low)
//   tx_status           status byte, loaded at frame start and per byte
//   move_ack            consumer acknowledge for the held move
//   move_valid          held move pending
//   move_player         01 = J1, 10 = J2
//   move_index          board cell index
//   frame_error         one-cycle pulse on aborted or illegal byte
//   overrun             sticky: accepted byte dropped while a move was held
//   busy                frame in progress (synchronized ss low)
//
// Optional: define MOVE_RANGE_CHECK_EN to reject indices >= NUM_CELLS.

module spi_slave_move_rx #(
    parameter int NUM_CELLS   = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       ss,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] tx_status,
    input  logic       move_ack,
    output logic       move_valid,
    output logic [1:0] move_player,
    output logic [5:0] move_index,
    output logic       frame_error,
    output logic       overrun,
    output logic       busy
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end

    if (NUM_CELLS < 1 || NUM_CELLS > 64) begin : g_bad_cells
        $error("NUM_CELLS must be in 1..64");
    end

    // Input synchronizers
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_dly_q;
    logic                   ss_dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            ss_dly_q    <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
            ss_dly_q    <= ss_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk_s;
    logic ss_s;
    logic mosi_s;
    logic active;
    logic sclk_rise;
    logic sclk_fall;
    logic ss_fall;
    logic ss_rise;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign active    = ~ss_s;
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign sclk_fall = ~sclk_s & sclk_dly_q;
    assign ss_fall   = ~ss_s & ss_dly_q;
    assign ss_rise   = ss_s & ~ss_dly_q;

    // Shift engine
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic [7:0] rx_q;
    logic [7:0] rx_d;
    logic [7:0] tx_q;
    logic [7:0] tx_d;
    logic       skip_q;
    logic       skip_d;
    logic       done;
    logic [7:0] rx_byte;

    always_comb begin
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        skip_d  = skip_q;
        done    = 1'b0;
        rx_byte = {rx_q[6:0], mosi_s};
        if (ss_fall) begin
            cnt_d  = 3'd0;
            tx_d   = tx_status;
            skip_d = 1'b0;
        end else if (active) begin
            if (sclk_rise) begin
                rx_d = rx_byte;
                if (cnt_q == 3'd7) begin
                    done  = 1'b1;
                    cnt_d = 3'd0;
                    tx_d  = tx_status;
                    // The falling edge that ends this byte must not shift
                    // away the freshly reloaded MSB of the next byte.
                    skip_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end else if (sclk_fall) begin
                if (skip_q) begin
                    skip_d = 1'b0;
                end else begin
                    tx_d = {tx_q[6:0], 1'b0};
                end
            end
        end else if (ss_rise) begin
            cnt_d  = 3'd0;
            skip_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 3'd0;
            rx_q   <= 8'd0;
            tx_q   <= 8'd0;
            skip_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rx_q   <= rx_d;
            tx_q   <= tx_d;
            skip_q <= skip_d;
        end
    end

    // Byte decode
    logic [1:0] dec_player;
    logic [5:0] dec_index;
    logic       player_ok;
    logic       index_ok;
    logic       accept;
    logic       reject;
    logic       abort;

    assign dec_player = rx_byte[7:6];
    assign dec_index  = rx_byte[5:0];
    assign player_ok  = (dec_player == 2'b01) || (dec_player == 2'b10);

`ifdef MOVE_RANGE_CHECK_EN
    localparam logic [6:0] NumCellsW = 7'(NUM_CELLS);
    assign index_ok = ({1'b0, dec_index} < NumCellsW);
`else
    assign index_ok = 1'b1;
`endif

    assign accept = done & player_ok & index_ok;
    assign reject = done & ~(player_ok & index_ok);
    assign abort  = ss_rise & (cnt_q != 3'd0);

    // Holding register and handshake
    logic       valid_q;
    logic       valid_d;
    logic [1:0] player_q;
    logic [1:0] player_d;
    logic [5:0] index_q;
    logic [5:0] index_d;
    logic       ovr_q;
    logic       ovr_d;
    logic       ferr_q;
    logic       ferr_d;

    always_comb begin
        valid_d  = valid_q;
        player_d = player_q;
        index_d  = index_q;
        ovr_d    = ovr_q;
        ferr_d   = reject | abort;
        if (valid_q && move_ack) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            if (valid_q && !move_ack) begin
                ovr_d = 1'b1;
            end else begin
                valid_d  = 1'b1;
                player_d = dec_player;
                index_d  = dec_index;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            player_q <= 2'd0;
            index_q  <= 6'd0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            player_q <= player_d;
            index_q  <= index_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
        end
    end

    assign miso        = active & tx_q[7];
    assign miso_oe     = active;
    assign busy        = active;
    assign move_valid  = valid_q;
    assign move_player = player_q;
    assign move_index  = index_q;
    assign frame_error = ferr_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_spi_slave_move_rx.sv
// Bench for spi_slave_move_rx: directed SPI frames at clk/16 with a
// move-level model checked every cycle plus literal expectations.

module tb_spi_slave_move_rx;

    localparam int SYNC = 2;
    localparam int HALF = 8;
`ifdef MOVE_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       ss;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_status;
    logic       move_ack;
    logic       move_valid;
    logic [1:0] move_player;
    logic [5:0] move_index;
    logic       frame_error;
    logic       overrun;
    logic       busy;

    spi_slave_move_rx #(.NUM_CELLS(9), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .ss(ss), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_status(tx_status),
        .move_ack(move_ack), .move_valid(move_valid),
        .move_player(move_player), .move_index(move_index),
        .frame_error(frame_error), .overrun(overrun), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Move-level model
    bit         exp_valid = 0;
    logic [1:0] exp_player = 0;
    logic [5:0] exp_idx = 0;
    bit         exp_ovr = 0;
    bit         exp_busy = 0;
    int         exp_ferr = 0;
    bit         chk_en = 0;

    int   ferr_cnt = 0;
    int   ferr_hi = 0;
    logic ferr_prev = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (frame_error === 1'b1) begin
            ferr_hi++;
            if (ferr_prev !== 1'b1) ferr_cnt++;
        end
        ferr_prev = frame_error;
        if (chk_en && rst_n) begin
            chk("cyc_valid", move_valid, exp_valid);
            if (exp_valid) begin
                chk("cyc_player", move_player, exp_player);
                chk("cyc_index", move_index, exp_idx);
            end
            chk("cyc_overrun", overrun, exp_ovr);
            chk("cyc_busy", busy, exp_busy);
            chk("cyc_miso_oe", miso_oe, exp_busy);
            if (!exp_busy) chk("cyc_miso_idle", miso, 0);
            chk("cyc_ferr_count", ferr_cnt, exp_ferr);
            chk("cyc_ferr_width", ferr_hi, ferr_cnt);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired actual=running required=done");
        $fatal(1, "watchdog");
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [1:0] p;
        logic [5:0] ix;
        bit ok;
        p  = b[7:6];
        ix = b[5:0];
        ok = (p == 2'b01 || p == 2'b10) && (!RC || ix < 6'd9);
        if (!ok) exp_ferr++;
        else if (exp_valid) exp_ovr = 1;
        else begin
            exp_valid  = 1;
            exp_player = p;
            exp_idx    = ix;
        end
    endtask

    task automatic start_frame();
        chk_en = 0;
        ss = 1'b0;
        wait_n(SYNC + 2);
        exp_busy = 1;
        chk_en = 1;
        wait_n(HALF - SYNC - 2);
    endtask

    task automatic end_frame(input bit aborted);
        chk_en = 0;
        ss = 1'b1;
        wait_n(SYNC + 2);
        exp_busy = 0;
        if (aborted) exp_ferr++;
        chk_en = 1;
        wait_n(HALF);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n,
                             output logic [7:0] rx);
        rx = 8'd0;
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            wait_n(HALF);
            sclk = 1'b1;
            rx = {rx[6:0], miso};
            if (i == 7) begin
                chk_en = 0;
                wait_n(SYNC + 2);
                model_byte(b);
                chk("latency_valid", move_valid, exp_valid);
                chk_en = 1;
                wait_n(HALF - SYNC - 2);
            end else begin
                wait_n(HALF);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic do_ack();
        move_ack = 1'b1;
        exp_valid = 0;
        @(negedge clk);
        move_ack = 1'b0;
        chk("ack_clear", move_valid, 0);
    endtask

    logic [7:0] r;
    logic [7:0] r2;
    int f0;

    initial begin
        rst_n = 1'b0;
        ss = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        move_ack = 1'b0;
        tx_status = 8'h00;
        wait_n(3);
        chk("rst_valid", move_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_ferr", frame_error, 0);
        chk("rst_busy", busy, 0);
        chk("rst_miso", {miso, miso_oe}, 0);
        chk("rst_move", {move_player, move_index}, 0);
        rst_n = 1'b1;
        wait_n(3);
        chk_en = 1;

        // J1 cell 3, master reads the status byte
        tx_status = 8'hA5;
        start_frame();
        send_bits(8'h43, 8, r);
        end_frame(0);
        chk("rx_status_a5", r, 8'hA5);
        chk("j1_valid", move_valid, 1);
        chk("j1_player", move_player, 2'b01);
        chk("j1_index", move_index, 6'd3);
        do_ack();

        // Held move plus a second byte -> overrun, no error
        f0 = ferr_cnt;
        start_frame();
        send_bits(8'h88, 8, r);
        end_frame(0);
        start_frame();
        send_bits(8'h42, 8, r);
        end_frame(0);
        chk("ovr_index_held", move_index, 6'd8);
        chk("ovr_player_held", move_player, 2'b10);
        chk("ovr_flag", overrun, 1);
        chk("ovr_no_ferr", ferr_cnt - f0, 0);
        do_ack();

        // Two-byte frame, status reloaded per byte
        tx_status = 8'h3C;
        start_frame();
        send_bits(8'h45, 8, r);
        send_bits(8'h87, 8, r2);
        end_frame(0);
        chk("mb_rx0", r, 8'h3C);
        chk("mb_rx1", r2, 8'h3C);
        chk("mb_index", move_index, 6'd5);
        chk("ovr_sticky", overrun, 1);
        do_ack();

        // Aborted frame, then cell 0
        f0 = ferr_cnt;
        start_frame();
        send_bits(8'hFF, 5, r);
        end_frame(1);
        chk("abort_ferr", ferr_cnt - f0, 1);
        chk("abort_valid", move_valid, 0);
        start_frame();
        send_bits(8'h40, 8, r);
        end_frame(0);
        chk("cell0_valid", move_valid, 1);
        chk("cell0_index", move_index, 6'd0);
        do_ack();

        // Illegal player field
        f0 = ferr_cnt;
        start_frame();
        send_bits(8'hC2, 8, r);
        end_frame(0);
        chk("p11_ferr", ferr_cnt - f0, 1);
        chk("p11_valid", move_valid, 0);

        // Out-of-board index
        f0 = ferr_cnt;
        start_frame();
        send_bits(8'h4C, 8, r);
        end_frame(0);
        chk("idx12_valid", move_valid, RC ? 32'd0 : 32'd1);
        chk("idx12_ferr", ferr_cnt - f0, RC ? 32'd1 : 32'd0);
        chk("idx12_index", move_valid ? move_index : 6'd12, 6'd12);
        do_ack();

        // Ack with nothing held is ignored
        do_ack();
        wait_n(3);
        chk("stray_ack", move_valid, 0);

        // Reset in the middle of a byte
        start_frame();
        send_bits(8'hFF, 4, r);
        chk_en = 0;
        rst_n = 1'b0;
        ss = 1'b1;
        wait_n(2);
        chk("mid_rst_outs",
            {move_valid, overrun, frame_error, busy, miso, miso_oe}, 0);
        exp_valid = 0;
        exp_ovr = 0;
        exp_busy = 0;
        rst_n = 1'b1;
        wait_n(4);
        chk_en = 1;
        start_frame();
        send_bits(8'h81, 8, r);
        end_frame(0);
        chk("post_rst_player", move_player, 2'b10);
        chk("post_rst_index", move_index, 6'd1);
        chk("post_rst_overrun", overrun, 0);
        do_ack();
        wait_n(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
